axis_pair_aligner: RTL and testbench

AXIS_PAIR_ALIGNER -- requirements
Module: axis_pair_aligner

---
 rtl/axis_pair_aligner.sv | 131 +++++++++++++
 tb/tb_axis_pair_aligner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pair_aligner.sv
// Aligns two AXI-Stream lanes: each lane buffers in its own FIFO and beats leave strictly in pairs.
// Optional stall watchdog is enabled by defining AXIS_PAIR_ALIGNER_TIMEOUT_EN.
module axis_pair_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 1024,
    localparam int AW        = $clog2(DEPTH),
    localparam int OW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in2_valid,
    output logic                  in2_ready,
    input  logic [DATA_WIDTH-1:0] in2_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic [31:0]           pair_count,
    output logic [OW-1:0]         occ1,
    output logic [OW-1:0]         occ2,
    output logic                  timeout
);

    logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem2 [DEPTH];
    logic [AW-1:0]         r_wr_ptr [2];
    logic [AW-1:0]         r_rd_ptr [2];
    logic [OW-1:0]         r_occ [2];
    logic [OW-1:0]         w_occ_nxt [2];
    logic [1:0]            r_rdy;
    logic [1:0]            w_push;
    logic                  w_vld;
    logic                  w_pop;
    logic [31:0]           r_pair_cnt;

    // Ready is a register computed from next occupancy, so it never sees out*_ready combinationally.
    assign w_push = {in2_valid & r_rdy[1], in1_valid & r_rdy[0]};
    assign w_vld  = (r_occ[0] != '0) && (r_occ[1] != '0);
    assign w_pop  = w_vld & out1_ready & out2_ready;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_occ_nxt[k] = r_occ[k];
            if (w_push[k] && !w_pop) begin
                w_occ_nxt[k] = r_occ[k] + OW'(1);
            end else if (!w_push[k] && w_pop) begin
                w_occ_nxt[k] = r_occ[k] - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_occ[k]    <= '0;
            end
            r_rdy      <= 2'b00;
            r_pair_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_push[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + AW'(1);
                end
                r_occ[k] <= w_occ_nxt[k];
                r_rdy[k] <= (w_occ_nxt[k] != OW'(DEPTH));
            end
            if (w_pop) begin
                r_pair_cnt <= r_pair_cnt + 32'd1;
            end
        end
    end

    // Storage is deliberately left out of reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push[0]) begin
            r_mem1[r_wr_ptr[0]] <= in1_data;
        end
        if (w_push[1]) begin
            r_mem2[r_wr_ptr[1]] <= in2_data;
        end
    end

    assign in1_ready  = r_rdy[0];
    assign in2_ready  = r_rdy[1];
    assign out1_valid = w_vld;
    assign out2_valid = w_vld;
    assign out1_data  = r_mem1[r_rd_ptr[0]];
    assign out2_data  = r_mem2[r_rd_ptr[1]];
    assign pair_count = r_pair_cnt;
    assign occ1       = r_occ[0];
    assign occ2       = r_occ[1];

`ifdef AXIS_PAIR_ALIGNER_TIMEOUT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] w_stall_nxt;
    logic        w_stall;
    logic        r_timeout;

    // A stall is exactly one lane holding data while its partner is empty.
    assign w_stall     = (r_occ[0] != '0) ^ (r_occ[1] != '0);
    assign w_stall_nxt = w_stall ? (r_stall_cnt + 32'd1) : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt == 32'(TIMEOUT)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0 & TIMEOUT[0];
`endif

endmodule

// File: tb/tb_axis_pair_aligner.sv
// Directed bench for axis_pair_aligner with DEPTH=4 and TIMEOUT=8.
module tb_axis_pair_aligner;

    localparam int DW = 32;
    localparam int DEPTH = 4;
`ifdef AXIS_PAIR_ALIGNER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          in1_valid, in1_ready, in2_valid, in2_ready;
    logic [DW-1:0] in1_data, in2_data;
    logic          out1_valid, out1_ready, out2_valid, out2_ready;
    logic [DW-1:0] out1_data, out2_data;
    logic [31:0]   pair_count;
    logic [2:0]    occ1, occ2;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    axis_pair_aligner #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data),
        .pair_count(pair_count), .occ1(occ1), .occ2(occ2), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sent1, sent2, npair;
        bit acc1, acc2;
        reset = 1'b1;
        in1_valid = 1'b0; in1_data = '0;
        in2_valid = 1'b0; in2_data = '0;
        out1_ready = 1'b1; out2_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        chk("rst_in2_ready", {31'd0, in2_ready}, 32'd0);
        chk("rst_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_occ1", {29'd0, occ1}, 32'd0);
        chk("rst_pair_count", pair_count, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in1_ready", {31'd0, in1_ready}, 32'd1);
        chk("post_rst_in2_ready", {31'd0, in2_ready}, 32'd1);

        // Test 1: in1 first, in2 three cycles later
        in1_valid = 1'b1; in1_data = 32'hA;
        tick();
        in1_valid = 1'b0;
        chk("t1_occ1", {29'd0, occ1}, 32'd1);
        chk("t1_valid_lone", {31'd0, out1_valid}, 32'd0);
        tick(); tick();
        chk("t1_valid_before_in2", {31'd0, out1_valid}, 32'd0);
        in2_valid = 1'b1; in2_data = 32'hB;
        tick();
        in2_valid = 1'b0;
        chk("t1_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("t1_out2_valid", {31'd0, out2_valid}, 32'd1);
        chk("t1_out1_data", out1_data, 32'hA);
        chk("t1_out2_data", out2_data, 32'hB);
        chk("t1_count_pre", pair_count, 32'd0);
        tick();
        chk("t1_count", pair_count, 32'd1);
        chk("t1_valid_after", {31'd0, out1_valid}, 32'd0);

        // Test 2: fill lane 1 with in2 idle, 5th beat must stall and survive
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_data = 32'h10 + 32'(i);
            tick();
        end
        chk("t2_occ1_full", {29'd0, occ1}, 32'd4);
        chk("t2_in1_ready_full", {31'd0, in1_ready}, 32'd0);
        in1_data = 32'h14;
        tick(); tick();
        chk("t2_occ1_held", {29'd0, occ1}, 32'd4);
        chk("t2_in1_ready_held", {31'd0, in1_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            in2_valid = 1'b1; in2_data = 32'h20 + 32'(i);
            acc1 = in1_valid && in1_ready;
            tick();
            if (acc1) in1_valid = 1'b0;
            chk("t2_pair_out1", out1_data, 32'h10 + 32'(i));
            chk("t2_pair_out2", out2_data, 32'h20 + 32'(i));
        end
        in2_valid = 1'b0;
        chk("t2_in1_released", {31'd0, in1_valid}, 32'd0);
        tick();
        chk("t2_occ1_empty", {29'd0, occ1}, 32'd0);
        chk("t2_occ2_empty", {29'd0, occ2}, 32'd0);
        chk("t2_count", pair_count, 32'd6);

        // Test 3: 100 beats per lane with random valid gaps
        sent1 = 0; sent2 = 0; npair = 0;
        for (int cyc = 0; cyc < 3000 && npair < 100; cyc++) begin
            if (out1_valid) begin
                chk("t3_out1_data", out1_data, 32'h1000_0000 + 32'(npair));
                chk("t3_out2_data", out2_data, 32'h2000_0000 + 32'(npair));
                npair++;
            end
            if (!in1_valid) begin
                in1_valid = (sent1 < 100) && ($urandom_range(0, 3) != 0);
                in1_data = 32'h1000_0000 + 32'(sent1);
            end
            if (!in2_valid) begin
                in2_valid = (sent2 < 100) && ($urandom_range(0, 2) != 0);
                in2_data = 32'h2000_0000 + 32'(sent2);
            end
            acc1 = in1_valid && in1_ready;
            acc2 = in2_valid && in2_ready;
            tick();
            if (acc1) begin sent1++; in1_valid = 1'b0; end
            if (acc2) begin sent2++; in2_valid = 1'b0; end
        end
        in1_valid = 1'b0; in2_valid = 1'b0;
        chk("t3_pairs_seen", 32'(npair), 32'd100);
        tick();
        chk("t3_count", pair_count, 32'd106);
        chk("t3_occ1", {29'd0, occ1}, 32'd0);
        chk("t3_occ2", {29'd0, occ2}, 32'd0);

        // Test 4: out2 back-pressure holds the pair
        out2_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 32'h55;
        in2_valid = 1'b1; in2_data = 32'h66;
        tick();
        in1_valid = 1'b0; in2_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_valid_held", {31'd0, out1_valid}, 32'd1);
            chk("t4_out1_held", out1_data, 32'h55);
            chk("t4_out2_held", out2_data, 32'h66);
            chk("t4_occ2_held", {29'd0, occ2}, 32'd1);
            chk("t4_count_held", pair_count, 32'd106);
        end
        in1_valid = 1'b1; in1_data = 32'h57;
        tick();
        in1_data = 32'h58;
        tick();
        in1_valid = 1'b0;
        chk("t4_occ1", {29'd0, occ1}, 32'd3);
        chk("t4_occ2", {29'd0, occ2}, 32'd1);
        chk("t4_out1_still", out1_data, 32'h55);

        // Test 5: reset mid-stream
        reset = 1'b1;
        #1;
        chk("t5_occ1", {29'd0, occ1}, 32'd0);
        chk("t5_occ2", {29'd0, occ2}, 32'd0);
        chk("t5_valid", {31'd0, out1_valid}, 32'd0);
        chk("t5_count", pair_count, 32'd0);
        chk("t5_in1_ready", {31'd0, in1_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_in1_ready_back", {31'd0, in1_ready}, 32'd1);
        chk("t5_in2_ready_back", {31'd0, in2_ready}, 32'd1);
        out2_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 32'h77;
        in2_valid = 1'b1; in2_data = 32'h88;
        tick();
        in1_valid = 1'b0; in2_valid = 1'b0;
        chk("t5_resume_out1", out1_data, 32'h77);
        chk("t5_resume_out2", out2_data, 32'h88);
        tick();
        chk("t5_resume_count", pair_count, 32'd1);

        // Test 6: watchdog on a lone lane-1 beat
        in1_valid = 1'b1; in1_data = 32'h99;
        tick();
        in1_valid = 1'b0;
        repeat (7) tick();
        chk("t6_timeout_7", {31'd0, timeout}, 32'd0);
        tick();
        chk("t6_timeout_8", {31'd0, timeout}, {31'd0, TO_EN});
        in2_valid = 1'b1; in2_data = 32'h9A;
        tick();
        in2_valid = 1'b0;
        chk("t6_out1", out1_data, 32'h99);
        chk("t6_out2", out2_data, 32'h9A);
        tick();
        chk("t6_timeout_sticky", {31'd0, timeout}, {31'd0, TO_EN});
        chk("t6_count", pair_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
